// File: rtl/pcie_os_symbol_mux_if.sv
// pcie_os_symbol_mux_if
//   Bus bundle between a transmit-path controller (master) and the
//   control-symbol / ordered-set mux (slave).
//   enb          advance enable; low freezes the mux
//   data_in      payload bytes, lane 0 in bits [7:0]
//   sel          single-symbol select (0 data, 1..9 K symbol, 10..15 hold)
//   os_req       ordered-set request: 0 none, 1 SKP, 2 FTS, 3 EIOS
//   os_ack       one-cycle pulse when a request is accepted
//   busy         ordered set in progress
//   data_out     registered output symbols
//   k_out        per-lane K flag
//   out_valid    data_out/k_out carry a new symbol this cycle
//   skp_pending  automatic SKP is due
interface pcie_os_symbol_mux_if #(
   parameter int unsigned LANES = 1
);
   logic                 enb;
   logic [8*LANES-1:0]   data_in;
   logic [3:0]           sel;
   logic [1:0]           os_req;
   logic                 os_ack;
   logic                 busy;
   logic [8*LANES-1:0]   data_out;
   logic [LANES-1:0]     k_out;
   logic                 out_valid;
   logic                 skp_pending;

   modport master (
      output enb, data_in, sel, os_req,
      input  os_ack, busy, data_out, k_out, out_valid, skp_pending
   );

   modport slave (
      input  enb, data_in, sel, os_req,
      output os_ack, busy, data_out, k_out, out_valid, skp_pending
   );
endinterface

// File: rtl/pcie_os_symbol_mux.sv
// pcie_os_symbol_mux
//   Multi-lane control-symbol mux for the PCIe PHY transmit path. Each enabled
//   cycle it registers either payload data, one of nine K symbols broadcast
//   to every lane, or the next symbol of a multi-symbol ordered set
//   (COM followed by OS_LEN-1 SKP / FTS / IDL fillers).
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    pcie_os_symbol_mux_if.slave (enb, data_in, sel, os_req in;
//            os_ack, busy, data_out, k_out, out_valid, skp_pending out)
//
//   Parameters:
//     LANES         byte lanes (1..8)
//     OS_LEN        symbols per ordered set including COM (2..16)
//     SKP_INTERVAL  enabled cycles between automatic SKP ordered sets
//
//   Build option:
//     SKP_SCHED_EN  when defined, an interval counter raises skp_pending and
//                   inserts SKP ordered sets on its own (no os_ack for those).
//                   When undefined, skp_pending is tied low.
module pcie_os_symbol_mux #(
   parameter int unsigned LANES        = 1,
   parameter int unsigned OS_LEN       = 4,
   parameter int unsigned SKP_INTERVAL = 1180
) (
   input  logic                 clk,
   input  logic                 reset,
   pcie_os_symbol_mux_if.slave  bus
);

   localparam logic [7:0] SYM_COM = 8'hBC;
   localparam logic [7:0] SYM_PAD = 8'hF7;
   localparam logic [7:0] SYM_SKP = 8'h1C;
   localparam logic [7:0] SYM_STP = 8'hFB;
   localparam logic [7:0] SYM_SDP = 8'h5C;
   localparam logic [7:0] SYM_END = 8'hFD;
   localparam logic [7:0] SYM_EDB = 8'hFE;
   localparam logic [7:0] SYM_FTS = 8'h3C;
   localparam logic [7:0] SYM_IDL = 8'h7C;

   localparam int unsigned CW = (OS_LEN > 2) ? $clog2(OS_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(OS_LEN - 1);

   typedef enum logic {
      S_IDLE,
      S_OS_SEND
   } state_t;

   typedef enum logic [1:0] {
      OS_NONE = 2'd0,
      OS_SKP  = 2'd1,
      OS_FTS  = 2'd2,
      OS_EIOS = 2'd3
   } os_t;

   state_t              state;
   os_t                 os_type;
   logic [CW-1:0]       cnt;

   logic [8*LANES-1:0]  data_q;
   logic [LANES-1:0]    k_q;
   logic                valid_q;
   logic                ack_q;
   logic                busy_q;
   logic                pend_q;

   logic [7:0]          sel_sym;
   logic [7:0]          fill_sym;
   logic                os_start;
   os_t                 start_type;

   // Single-symbol lookup; sel 0 and 10..15 never reach the output through
   // this path, so their value here is don't-care.
   always_comb begin
      sel_sym = '0;
      unique case (bus.sel)
         4'd1:    sel_sym = SYM_COM;
         4'd2:    sel_sym = SYM_PAD;
         4'd3:    sel_sym = SYM_SKP;
         4'd4:    sel_sym = SYM_STP;
         4'd5:    sel_sym = SYM_SDP;
         4'd6:    sel_sym = SYM_END;
         4'd7:    sel_sym = SYM_EDB;
         4'd8:    sel_sym = SYM_FTS;
         4'd9:    sel_sym = SYM_IDL;
         default: sel_sym = '0;
      endcase
   end

   always_comb begin
      fill_sym = SYM_IDL;
      unique case (os_type)
         OS_SKP:  fill_sym = SYM_SKP;
         OS_FTS:  fill_sym = SYM_FTS;
         default: fill_sym = SYM_IDL;
      endcase
   end

   // An explicit request outranks a due automatic SKP; the automatic one is
   // always a SKP set.
   always_comb begin
      os_start   = (bus.os_req != 2'd0) || pend_q;
      start_type = (bus.os_req != 2'd0) ? os_t'(bus.os_req) : OS_SKP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         os_type <= OS_NONE;
         cnt     <= '0;
         data_q  <= '0;
         k_q     <= '0;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         if (bus.enb) begin
            unique case (state)
               S_IDLE: begin
                  busy_q <= 1'b0;
                  if (os_start) begin
                     os_type <= start_type;
                     data_q  <= {LANES{SYM_COM}};
                     k_q     <= '1;
                     valid_q <= 1'b1;
                     ack_q   <= (bus.os_req != 2'd0);
                     busy_q  <= 1'b1;
                     cnt     <= CW'(1);
                     state   <= S_OS_SEND;
                  end else if (bus.sel == 4'd0) begin
                     data_q  <= bus.data_in;
                     k_q     <= '0;
                     valid_q <= 1'b1;
                  end else if (bus.sel <= 4'd9) begin
                     data_q  <= {LANES{sel_sym}};
                     k_q     <= '1;
                     valid_q <= 1'b1;
                  end
               end
               S_OS_SEND: begin
                  data_q  <= {LANES{fill_sym}};
                  k_q     <= '1;
                  valid_q <= 1'b1;
                  // busy stays up while the last filler is on the output and
                  // drops on the following IDLE cycle unless a new set starts.
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= S_IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef SKP_SCHED_EN
   localparam int unsigned IW = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
   localparam logic [IW-1:0] IVL_MAX = IW'(SKP_INTERVAL - 1);

   logic [IW-1:0] ivl_cnt;
   logic [IW-1:0] ivl_next;
   logic          skp_start;

   // Any SKP set starting this cycle, requested or scheduled, restarts the
   // interval.
   always_comb begin
      skp_start = bus.enb && (state == S_IDLE) &&
                  ((bus.os_req == 2'd1) || ((bus.os_req == 2'd0) && pend_q));
      ivl_next  = (ivl_cnt == IVL_MAX) ? ivl_cnt : ivl_cnt + IW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ivl_cnt <= '0;
         pend_q  <= 1'b0;
      end else if (skp_start) begin
         ivl_cnt <= '0;
         pend_q  <= 1'b0;
      end else if (bus.enb) begin
         ivl_cnt <= ivl_next;
         pend_q  <= (ivl_next == IVL_MAX);
      end
   end
`else
   logic unused_skp_interval;

   always_comb begin
      pend_q              = 1'b0;
      unused_skp_interval = ^SKP_INTERVAL;
   end
`endif

   assign bus.data_out    = data_q;
   assign bus.k_out       = k_q;
   assign bus.out_valid   = valid_q;
   assign bus.os_ack      = ack_q;
   assign bus.busy        = busy_q;
   assign bus.skp_pending = pend_q;

endmodule

// File: tb/tb_pcie_os_symbol_mux.sv
// tb_pcie_os_symbol_mux
//   Self-checking bench for pcie_os_symbol_mux with LANES=4, OS_LEN=4,
//   SKP_INTERVAL=8. Each scenario task builds a table of stimulus steps with
//   the outputs expected one clock later, pushes the expectation to a
//   scoreboard queue as the step is driven and pops it once the DUT has
//   registered the result.
//   Observed vector: {data_out[31:0], k_out[3:0], out_valid, os_ack, busy,
//   skp_pending}.
module tb_pcie_os_symbol_mux;

   typedef logic [39:0] obs_t;

   typedef struct {
      logic        rst;
      logic        en;
      logic [3:0]  sel;
      logic [1:0]  req;
      logic [31:0] din;
      obs_t        want;
   } step_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   obs_t exp_q[$];

   logic [7:0] syms [1:9] = '{8'hBC, 8'hF7, 8'h1C, 8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h3C, 8'h7C};

   pcie_os_symbol_mux_if #(.LANES(4)) bus ();

   pcie_os_symbol_mux #(
      .LANES(4),
      .OS_LEN(4),
      .SKP_INTERVAL(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(logic [31:0] d, logic [3:0] k, logic v, logic a, logic b, logic p);
      return {d, k, v, a, b, p};
   endfunction

   function automatic step_t st(logic r, logic e, logic [3:0] s, logic [1:0] q, logic [31:0] din, obs_t w);
      step_t x;
      x.rst = r; x.en = e; x.sel = s; x.req = q; x.din = din; x.want = w;
      return x;
   endfunction

   function automatic obs_t observe();
      return {bus.data_out, bus.k_out, bus.out_valid, bus.os_ack, bus.busy, bus.skp_pending};
   endfunction

   task automatic apply(input step_t s);
      reset       = s.rst;
      bus.enb     = s.en;
      bus.sel     = s.sel;
      bus.os_req  = s.req;
      bus.data_in = s.din;
   endtask

   task automatic test_reset();
      step_t s[$];
      obs_t got, want;
      s.push_back(st(1, 1, 4'd1, 2'd1, 32'hFFFF_FFFF, '0));
      s.push_back(st(1, 0, 4'd0, 2'd0, 32'h0, '0));
      foreach (s[i]) begin
         apply(s[i]);
         exp_q.push_back(s[i].want);
         @(posedge clk); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_passthrough();
      step_t s[$];
      obs_t got, want;
      s.push_back(st(1, 1, 4'd0, 2'd0, 32'h0, '0));
      s.push_back(st(0, 1, 4'd0, 2'd0, 32'h4433_2211, mk(32'h4433_2211, 4'h0, 1, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd0, 2'd0, 32'hA5C3_0F96, mk(32'hA5C3_0F96, 4'h0, 1, 0, 0, 0)));
      s.push_back(st(1, 1, 4'd0, 2'd0, 32'h1357_9BDF, '0));
      foreach (s[i]) begin
         apply(s[i]);
         exp_q.push_back(s[i].want);
         @(posedge clk); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL passthrough[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_symbols();
      step_t s[$];
      obs_t got, want;
      s.push_back(st(1, 1, 4'd0, 2'd0, 32'h0, '0));
      for (int i = 1; i <= 9; i++)
         s.push_back(st(0, 1, 4'(i), 2'd0, 32'hDEAD_BEEF, mk({4{syms[i]}}, 4'hF, 1, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd1,  2'd0, 32'h0, mk(32'hBCBC_BCBC, 4'hF, 1, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd5,  2'd0, 32'h0, mk(32'h5C5C_5C5C, 4'hF, 1, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd9,  2'd0, 32'h0, mk(32'h7C7C_7C7C, 4'hF, 1, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd12, 2'd0, 32'h0, mk(32'h7C7C_7C7C, 4'hF, 0, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd15, 2'd0, 32'h0, mk(32'h7C7C_7C7C, 4'hF, 0, 0, 0, 0)));
      s.push_back(st(0, 0, 4'd2,  2'd1, 32'h0, mk(32'h7C7C_7C7C, 4'hF, 0, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd0,  2'd0, 32'h0BAD_F00D, mk(32'h0BAD_F00D, 4'h0, 1, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i]);
         exp_q.push_back(s[i].want);
         @(posedge clk); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL symbols[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_os_skp();
      step_t s[$];
      obs_t got, want;
      s.push_back(st(1, 1, 4'd0, 2'd0, 32'h0, '0));
      s.push_back(st(0, 1, 4'd2, 2'd1, 32'h0, mk(32'hBCBC_BCBC, 4'hF, 1, 1, 1, 0)));
      for (int i = 0; i < 3; i++)
         s.push_back(st(0, 1, 4'd2, 2'd0, 32'h0, mk(32'h1C1C_1C1C, 4'hF, 1, 0, 1, 0)));
      s.push_back(st(0, 1, 4'd2, 2'd0, 32'h0, mk(32'hF7F7_F7F7, 4'hF, 1, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i]);
         exp_q.push_back(s[i].want);
         @(posedge clk); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL os_skp[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_os_eios_stall();
      step_t s[$];
      obs_t got, want;
      s.push_back(st(1, 1, 4'd0, 2'd0, 32'h0, '0));
      s.push_back(st(0, 1, 4'd0, 2'd3, 32'h0, mk(32'hBCBC_BCBC, 4'hF, 1, 1, 1, 0)));
      s.push_back(st(0, 0, 4'd0, 2'd0, 32'h0, mk(32'hBCBC_BCBC, 4'hF, 0, 0, 1, 0)));
      s.push_back(st(0, 0, 4'd0, 2'd0, 32'h0, mk(32'hBCBC_BCBC, 4'hF, 0, 0, 1, 0)));
      for (int i = 0; i < 3; i++)
         s.push_back(st(0, 1, 4'd0, 2'd0, 32'h0, mk(32'h7C7C_7C7C, 4'hF, 1, 0, 1, 0)));
      s.push_back(st(0, 1, 4'd0, 2'd0, 32'h1122_3344, mk(32'h1122_3344, 4'h0, 1, 0, 0, 0)));
      // reset while the second IDL is on the output aborts the set
      s.push_back(st(0, 1, 4'd0, 2'd3, 32'h0, mk(32'hBCBC_BCBC, 4'hF, 1, 1, 1, 0)));
      s.push_back(st(0, 1, 4'd0, 2'd0, 32'h0, mk(32'h7C7C_7C7C, 4'hF, 1, 0, 1, 0)));
      s.push_back(st(0, 1, 4'd0, 2'd0, 32'h0, mk(32'h7C7C_7C7C, 4'hF, 1, 0, 1, 0)));
      s.push_back(st(1, 1, 4'd0, 2'd0, 32'h0, '0));
      s.push_back(st(0, 1, 4'd0, 2'd0, 32'hCAFE_F00D, mk(32'hCAFE_F00D, 4'h0, 1, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i]);
         exp_q.push_back(s[i].want);
         @(posedge clk); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL os_eios_stall[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      obs_t got, want;
      s.push_back(st(1, 1, 4'd0, 2'd0, 32'h0, '0));
      for (int n = 0; n < 2; n++) begin
         s.push_back(st(0, 1, 4'd0, 2'd2, 32'h5A5A_5A5A, mk(32'hBCBC_BCBC, 4'hF, 1, 1, 1, 0)));
         for (int i = 0; i < 3; i++)
            s.push_back(st(0, 1, 4'd0, 2'd2, 32'h5A5A_5A5A, mk(32'h3C3C_3C3C, 4'hF, 1, 0, 1, 0)));
      end
      s.push_back(st(0, 1, 4'd0, 2'd0, 32'h5A5A_5A5A, mk(32'h5A5A_5A5A, 4'h0, 1, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i]);
         exp_q.push_back(s[i].want);
         @(posedge clk); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_skp_sched();
      step_t s[$];
      obs_t got, want;
      logic [31:0] d;
      d = 32'h0102_0304;
      s.push_back(st(1, 1, 4'd0, 2'd0, d, '0));
      for (int i = 1; i <= 6; i++)
         s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(d, 4'h0, 1, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(d, 4'h0, 1, 0, 0, 1)));
      s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(32'hBCBC_BCBC, 4'hF, 1, 0, 1, 0)));
      for (int i = 0; i < 3; i++)
         s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(32'h1C1C_1C1C, 4'hF, 1, 0, 1, 0)));
      for (int i = 0; i < 3; i++)
         s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(d, 4'h0, 1, 0, 0, 0)));
      s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(d, 4'h0, 1, 0, 0, 1)));
      // explicit FTS request wins over the due SKP, which follows at once
      s.push_back(st(0, 1, 4'd0, 2'd2, d, mk(32'hBCBC_BCBC, 4'hF, 1, 1, 1, 1)));
      for (int i = 0; i < 3; i++)
         s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(32'h3C3C_3C3C, 4'hF, 1, 0, 1, 1)));
      s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(32'hBCBC_BCBC, 4'hF, 1, 0, 1, 0)));
      for (int i = 0; i < 3; i++)
         s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(32'h1C1C_1C1C, 4'hF, 1, 0, 1, 0)));
      s.push_back(st(0, 1, 4'd0, 2'd0, d, mk(d, 4'h0, 1, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i]);
         exp_q.push_back(s[i].want);
         @(posedge clk); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL skp_sched[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      reset       = 1'b1;
      bus.enb     = 1'b0;
      bus.sel     = 4'd0;
      bus.os_req  = 2'd0;
      bus.data_in = '0;
      test_reset();
`ifdef SKP_SCHED_EN
      test_skp_sched();
`else
      test_passthrough();
      test_symbols();
      test_os_skp();
      test_os_eios_stall();
      test_back_to_back();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running want=finished");
      $fatal(1, "watchdog");
   end

endmodule
